// File: rtl/mips_mem_pkg.sv
// Shared M-stage memory definitions: opcodes, access types, FSM encoding and decode helpers.
// Purely declarative; no latency or backpressure of its own.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [2:0] {
        MT_BYTE_S = 3'd0,
        MT_BYTE_U = 3'd1,
        MT_HALF_S = 3'd2,
        MT_HALF_U = 3'd3,
        MT_WORD   = 3'd4
    } mem_type_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic      is_mem;
        logic      is_store;
        mem_type_t mtype;
    } mem_op_t;

    // Opcode-only decode; stores reuse the unsigned types since no extension applies.
    function automatic mem_op_t decode_op(input logic [5:0] opcode);
        mem_op_t d;
        d.is_mem   = 1'b1;
        d.is_store = 1'b0;
        d.mtype    = MT_WORD;
        case (opcode)
            OP_LB:  d.mtype = MT_BYTE_S;
            OP_LBU: d.mtype = MT_BYTE_U;
            OP_LH:  d.mtype = MT_HALF_S;
            OP_LHU: d.mtype = MT_HALF_U;
            OP_LW:  d.mtype = MT_WORD;
            OP_SB: begin
                d.is_store = 1'b1;
                d.mtype    = MT_BYTE_U;
            end
            OP_SH: begin
                d.is_store = 1'b1;
                d.mtype    = MT_HALF_U;
            end
            OP_SW: begin
                d.is_store = 1'b1;
                d.mtype    = MT_WORD;
            end
            default: d.is_mem = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic is_aligned(input mem_type_t t, input logic [1:0] a);
        logic ok;
        case (t)
            MT_WORD:              ok = (a == 2'b00);
            MT_HALF_S, MT_HALF_U: ok = ~a[0];
            default:              ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering: byte enables + replicated store data, and lane select + extension of load data.
// Purely combinational, zero latency, no backpressure.
module mem_lane_align
    import mips_mem_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int BE_W   = DATA_W / 8,
    localparam int LANE_W = $clog2(DATA_W / 8)
) (
    input  mem_type_t           st_type,
    input  logic [LANE_W-1:0]   st_lane,
    input  logic [31:0]         st_wdata,
    output logic [BE_W-1:0]     st_be,
    output logic [DATA_W-1:0]   st_bus,
    input  logic [DATA_W-1:0]   ld_rdata,
    input  logic [LANE_W-1:0]   ld_lane,
    input  mem_type_t           ld_type,
    output logic [31:0]         ld_data
);

    logic [31:0] ld_word;

    always_comb begin
        st_be  = '0;
        st_bus = '0;
        case (st_type)
            MT_BYTE_S, MT_BYTE_U: begin
                st_be  = BE_W'(1) << st_lane;
                st_bus = {(DATA_W / 8){st_wdata[7:0]}};
            end
            MT_HALF_S, MT_HALF_U: begin
                st_be  = BE_W'(2'b11) << st_lane;
                st_bus = {(DATA_W / 16){st_wdata[15:0]}};
            end
            default: begin
                st_be  = BE_W'(4'b1111) << st_lane;
                st_bus = {(DATA_W / 32){st_wdata}};
            end
        endcase
    end

    // Shift the addressed lane down to bit 0; only the low word is ever needed.
    assign ld_word = 32'(ld_rdata >> {ld_lane, 3'b000});

    always_comb begin
        ld_data = ld_word;
        case (ld_type)
            MT_BYTE_S: ld_data = {{24{ld_word[7]}}, ld_word[7:0]};
            MT_BYTE_U: ld_data = {24'b0, ld_word[7:0]};
            MT_HALF_S: ld_data = {{16{ld_word[15]}}, ld_word[15:0]};
            MT_HALF_U: ld_data = {16'b0, ld_word[15:0]};
            default:   ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage load/store unit: decode, alignment check, req/ready bus handshake with timeout.
// Min 3 cycles per access (issue, ACCESS+ready, DONE); stalls M while the bus withholds mem_ready.
module mem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  m_valid,
    input  logic [31:0]           m_instr,
    input  logic [ADDR_W-1:0]     m_addr,
    input  logic [31:0]           m_wdata,
    input  logic                  flush,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall_m,
    output logic [31:0]           load_data,
    output logic                  load_valid,
    output logic                  exc_adel,
    output logic                  exc_ades,
    output logic                  exc_timeout
);

    localparam int BE_W   = DATA_W / 8;
    localparam int LANE_W = $clog2(BE_W);
    localparam int CNT_W  = $clog2(MAX_WAIT + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic              we;
        logic [DATA_W-1:0] wdata;
        mem_type_t         mtype;
        logic [LANE_W-1:0] lane;
    } req_t;

    state_t            state;
    req_t              req;
    logic [CNT_W-1:0]  wait_cnt;
    logic              cancel;
    logic [31:0]       load_data_q;

    mem_op_t           op;
    logic              memop;
    logic              aligned;
    logic              start;
    logic              misaligned;
    logic              in_access;
    logic              timeout_now;
    logic              cancel_next;
    logic [BE_W-1:0]   st_be;
    logic [DATA_W-1:0] st_bus;
    logic [31:0]       ld_ext;
    logic              unused_instr;

    assign op           = decode_op(m_instr[31:26]);
    assign unused_instr = ^m_instr[25:0];

    assign memop      = m_valid & ~flush & op.is_mem;
    assign aligned    = is_aligned(op.mtype, m_addr[1:0]);
    assign start      = (state == IDLE) & memop & aligned;
    assign misaligned = (state == IDLE) & memop & ~aligned;
    assign in_access  = (state == ACCESS);

    // Terminal count: one more unanswered cycle would push the count past MAX_WAIT.
    // A simultaneous mem_ready takes priority.
    assign timeout_now = in_access & ~mem_ready & (wait_cnt == CNT_W'(MAX_WAIT));
    assign cancel_next = cancel | flush;

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .st_type  (op.mtype),
        .st_lane  (m_addr[LANE_W-1:0]),
        .st_wdata (m_wdata),
        .st_be    (st_be),
        .st_bus   (st_bus),
        .ld_rdata (mem_rdata),
        .ld_lane  (req.lane),
        .ld_type  (req.mtype),
        .ld_data  (ld_ext)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            req         <= '0;
            wait_cnt    <= '0;
            cancel      <= 1'b0;
            load_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        req.addr  <= m_addr;
                        req.be    <= st_be;
                        req.we    <= op.is_store;
                        req.wdata <= st_bus;
                        req.mtype <= op.mtype;
                        req.lane  <= m_addr[LANE_W-1:0];
                        wait_cnt  <= '0;
                        cancel    <= 1'b0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    cancel <= cancel_next;
                    if (mem_ready) begin
                        // A flushed load still finishes on the bus but its result is discarded.
                        if (!req.we && !cancel_next) begin
                            load_data_q <= ld_ext;
                        end
                        state <= DONE;
                    end else if (timeout_now) begin
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    cancel   <= 1'b0;
                    wait_cnt <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req     = in_access;
    assign mem_we      = in_access & req.we;
    assign mem_be      = in_access ? req.be : '0;
    assign mem_addr    = {req.addr[ADDR_W-1:LANE_W], LANE_W'(0)};
    assign mem_wdata   = req.wdata;
    assign stall_m     = start | (in_access & ~timeout_now);
    assign load_data   = load_data_q;
    assign load_valid  = (state == DONE) & ~req.we & ~cancel;
    assign exc_adel    = misaligned & ~op.is_store;
    assign exc_ades    = misaligned & op.is_store;
    assign exc_timeout = timeout_now;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized scoreboard bench for mem_access_ctrl on a 64-bit bus with a short timeout.
// The driver also plays the memory; a negedge monitor pops expected bus/load/exception/stall events.
module tb_mem_access_ctrl;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 32;
    localparam int MAX_WAIT = 3;
    localparam int NO_FLUSH = 99;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b0;
    logic              m_valid   = 1'b0;
    logic [31:0]       m_instr   = '0;
    logic [31:0]       m_addr    = '0;
    logic [31:0]       m_wdata   = '0;
    logic              flush     = 1'b0;
    logic              mem_ready = 1'b0;
    logic [63:0]       mem_rdata = '0;
    logic              mem_req, mem_we, stall_m, load_valid;
    logic              exc_adel, exc_ades, exc_timeout;
    logic [7:0]        mem_be;
    logic [31:0]       mem_addr, load_data;
    logic [63:0]       mem_wdata;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  be;
        logic        we;
        logic [63:0] wdata;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    logic [31:0] load_q[$];
    logic [2:0]  exc_q[$];
    int          stall_q[$];
    int          checks = 0;
    int          errors = 0;

    mem_access_ctrl #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .m_valid     (m_valid),
        .m_instr     (m_instr),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .stall_m     (stall_m),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .exc_adel    (exc_adel),
        .exc_ades    (exc_ades),
        .exc_timeout (exc_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h with no expectation pending (t=%0t)", name, act, $time);
    endtask

    // op index: 0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw, 5 sb, 6 sh, 7 sw, 8 non-memory
    task automatic op_info(input int op, output logic [5:0] opc, output int size,
                           output bit sgn, output bit st, output bit mem);
        mem = 1'b1; sgn = 1'b0; st = 1'b0; size = 4;
        case (op)
            0: begin opc = 6'b100000; size = 1; sgn = 1'b1; end
            1: begin opc = 6'b100100; size = 1; end
            2: begin opc = 6'b100001; size = 2; sgn = 1'b1; end
            3: begin opc = 6'b100101; size = 2; end
            4: begin opc = 6'b100011; end
            5: begin opc = 6'b101000; size = 1; st = 1'b1; end
            6: begin opc = 6'b101001; size = 2; st = 1'b1; end
            7: begin opc = 6'b101011; st = 1'b1; end
            default: begin
                mem = 1'b0;
                case ($urandom_range(0, 4))
                    0:       opc = 6'b000000;
                    1:       opc = 6'b001000;
                    2:       opc = 6'b100010;
                    3:       opc = 6'b101010;
                    default: opc = 6'b110001;
                endcase
            end
        endcase
    endtask

    // Reference model: works from access size, address arithmetic and integer extension.
    task automatic model(input int op, input logic [5:0] opc, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [63:0] rd, input int w,
                         input int fidx, input bit fl, input bit vld, output bit exp_acc);
        logic [5:0]  opc_chk;
        int          size, lane;
        bit          sgn, st, mem;
        logic [63:0] span, wrep, v;
        bus_exp_t    e;
        op_info(op, opc_chk, size, sgn, st, mem);
        exp_acc = 1'b0;
        if (!(vld && !fl && mem)) return;
        if ((addr % 32'(size)) != 0) begin
            exc_q.push_back(st ? 3'b010 : 3'b001);
            return;
        end
        exp_acc = 1'b1;
        lane = int'(addr % 32'(DATA_W / 8));
        if (w > MAX_WAIT) begin
            stall_q.push_back(MAX_WAIT + 1);
            exc_q.push_back(3'b100);
            return;
        end
        stall_q.push_back(w + 2);
        span = 64'd1 << (8 * size);
        wrep = '0;
        for (int i = 0; i < DATA_W / 8; i += size)
            wrep = wrep | ((64'(wd) % span) << (8 * i));
        e.addr  = addr - (addr % 32'(DATA_W / 8));
        e.be    = 8'(((1 << size) - 1) << lane);
        e.we    = st;
        e.wdata = wrep;
        bus_q.push_back(e);
        if (!st && !(fidx <= w)) begin
            v = (rd >> (8 * lane)) % span;
            if (sgn && v >= span / 2) v = v - span;
            load_q.push_back(v[31:0]);
        end
    endtask

    task automatic run_txn(input int op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [63:0] rd, input int w, input int fidx,
                           input bit fl, input bit vld);
        logic [5:0] opc;
        int         size, acc;
        bit         sgn, st, mem, exp_acc;
        op_info(op, opc, size, sgn, st, mem);
        model(op, opc, addr, wd, rd, w, fidx, fl, vld, exp_acc);
        @(posedge clk); #1;
        m_valid   = vld;
        m_instr   = {opc, 26'($urandom)};
        m_addr    = addr;
        m_wdata   = wd;
        flush     = fl;
        mem_rdata = rd;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        if (!exp_acc) m_valid = 1'b0;
        acc = 0;
        while (mem_req && acc < 40) begin
            mem_ready = (acc == w);
            flush     = (acc == fidx);
            @(posedge clk); #1;
            acc++;
        end
        if (acc >= 40) flag_fail("access_never_ends", 64'(acc));
        m_valid   = 1'b0;
        mem_ready = 1'b0;
        flush     = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"},    64'(mem_req),    64'd0);
        check({tag, "_mem_we"},     64'(mem_we),     64'd0);
        check({tag, "_mem_be"},     64'(mem_be),     64'd0);
        check({tag, "_mem_addr"},   64'(mem_addr),   64'd0);
        check({tag, "_mem_wdata"},  mem_wdata,       64'd0);
        check({tag, "_stall_m"},    64'(stall_m),    64'd0);
        check({tag, "_load_valid"}, 64'(load_valid), 64'd0);
        check({tag, "_load_data"},  64'(load_data),  64'd0);
        check({tag, "_exc"},        64'({exc_timeout, exc_ades, exc_adel}), 64'd0);
    endtask

    // Reset in the middle of an outstanding lw: the transfer is abandoned.
    task automatic reset_mid_access();
        @(posedge clk); #1;
        m_valid   = 1'b1;
        m_instr   = {6'b100011, 26'd0};
        m_addr    = 32'h0000_7008;
        mem_rdata = 64'h1111_2222_3333_4444;
        mem_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        m_valid = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        int          run;
        logic [31:0] hold_ref;
        logic [2:0]  code;
        bus_exp_t    e;
        run = 0;
        hold_ref = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                run = 0;
                hold_ref = '0;
                continue;
            end
            if (mem_req && mem_ready) begin
                if (bus_q.size() == 0) flag_fail("bus_unexpected", 64'(mem_addr));
                else begin
                    e = bus_q.pop_front();
                    check("bus_addr", 64'(mem_addr), 64'(e.addr));
                    check("bus_be",   64'(mem_be),   64'(e.be));
                    check("bus_we",   64'(mem_we),   64'(e.we));
                    if (e.we) check("bus_wdata", mem_wdata, e.wdata);
                end
            end
            if (load_valid) begin
                if (load_q.size() == 0) flag_fail("load_unexpected", 64'(load_data));
                else begin
                    hold_ref = load_q.pop_front();
                    check("load_data", 64'(load_data), 64'(hold_ref));
                end
            end else begin
                check("load_hold", 64'(load_data), 64'(hold_ref));
            end
            code = {exc_timeout, exc_ades, exc_adel};
            if (code != 3'b000) begin
                if (exc_q.size() == 0) flag_fail("exc_unexpected", 64'(code));
                else check("exc_code", 64'(code), 64'(exc_q.pop_front()));
            end
            if (stall_m) run++;
            else if (run > 0) begin
                if (stall_q.size() == 0) flag_fail("stall_unexpected", 64'(run));
                else check("stall_cycles", 64'(run), 64'(stall_q.pop_front()));
                run = 0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int          op, w, fidx;
        bit          fl, vld;
        logic [31:0] a, wd;
        logic [63:0] rd;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;

        run_txn(0, 32'h0000_1003, 32'h0,         64'h0000_0000_80FF_0000, 2, NO_FLUSH, 1'b0, 1'b1);
        run_txn(6, 32'h0000_2006, 32'h1234_ABCD, 64'h0,                   0, NO_FLUSH, 1'b0, 1'b1);
        run_txn(4, 32'h0000_3002, 32'h0,         64'h0,                   0, NO_FLUSH, 1'b0, 1'b1);
        run_txn(6, 32'h0000_3003, 32'h0,         64'h0,                   0, NO_FLUSH, 1'b0, 1'b1);
        run_txn(7, 32'h0000_5000, 32'hDEAD_BEEF, 64'h0,                  10, NO_FLUSH, 1'b0, 1'b1);
        run_txn(7, 32'h0000_5004, 32'hCAFE_F00D, 64'h0,            MAX_WAIT, NO_FLUSH, 1'b0, 1'b1);
        run_txn(3, 32'h0000_4002, 32'h0,         64'h0000_0000_8001_0000, 1, 0,        1'b0, 1'b1);
        run_txn(3, 32'h0000_4002, 32'h0,         64'h0000_0000_8001_0000, 1, NO_FLUSH, 1'b0, 1'b1);
        run_txn(2, 32'h0000_4006, 32'h0,         64'h8001_0000_0000_0000, 0, NO_FLUSH, 1'b0, 1'b1);
        run_txn(4, 32'h0000_6000, 32'h0,         64'h0,                   1, NO_FLUSH, 1'b1, 1'b1);
        reset_mid_access();
        run_txn(4, 32'h0000_6004, 32'h0,         64'h89AB_CDEF_0123_4567, 0, NO_FLUSH, 1'b0, 1'b1);

        for (int n = 0; n < 400; n++) begin
            op   = $urandom_range(0, 8);
            a    = $urandom;
            wd   = $urandom;
            rd   = {$urandom, $urandom};
            w    = $urandom_range(0, 5);
            fidx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : NO_FLUSH;
            fl   = ($urandom_range(0, 9) == 0);
            vld  = ($urandom_range(0, 9) != 0);
            run_txn(op, a, wd, rd, w, fidx, fl, vld);
        end

        repeat (5) @(posedge clk);
        #1;
        check("bus_q_drained",   64'(bus_q.size()),   64'd0);
        check("load_q_drained",  64'(load_q.size()),  64'd0);
        check("exc_q_drained",   64'(exc_q.size()),   64'd0);
        check("stall_q_drained", 64'(stall_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
